// File: rtl/servo_slew_ctrl.sv
// APB3 servo slew controller: moves the commanded pulse width toward a target
// by at most one step per servo frame and flags completion with an interrupt.
module servo_slew_ctrl #(
    parameter int FRAME_CYCLES = 2000000,
    parameter int MIN_WIDTH    = 50000,
    parameter int MAX_WIDTH    = 250000,
    parameter int RESET_WIDTH  = 90000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [23:0] width,
    output logic        width_strobe,
    output logic        FABINT
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [23:0] MIN_W   = 24'(MIN_WIDTH);
    localparam logic [23:0] MAX_W   = 24'(MAX_WIDTH);
    localparam logic [23:0] RESET_W = 24'(RESET_WIDTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_MOVING = 1'b1;

    localparam logic [2:0] A_TARGET  = 3'd0;
    localparam logic [2:0] A_STEP    = 3'd1;
    localparam logic [2:0] A_CTRL    = 3'd2;
    localparam logic [2:0] A_STATUS  = 3'd3;
    localparam logic [2:0] A_CURRENT = 3'd4;

    function automatic logic [23:0] clamp_width(input logic [23:0] v);
        if (v < MIN_W) begin
            return MIN_W;
        end else if (v > MAX_W) begin
            return MAX_W;
        end else begin
            return v;
        end
    endfunction

    logic [CNT_W-1:0] count_r;
    logic [23:0]      target_r;
    logic [15:0]      step_r;
    logic             enable_r;
    logic             irq_en_r;
    logic             done_r;
    logic [0:0]       state_r;
    logic [23:0]      width_r;
    logic             strobe_r;

    logic        tick_s;
    logic [2:0]  addr_s;
    logic        bad_addr_s;
    logic        wr_ok_s;
    logic        up_s;
    logic [24:0] diff_s;
    logic        near_s;
    logic [0:0]  state_n_s;
    logic [23:0] width_n_s;
    logic        strobe_n_s;
    logic        done_set_s;
    logic [31:0] rdata_s;

    assign tick_s     = (count_r == CNT_LAST);
    assign addr_s     = PADDR[4:2];
    assign bad_addr_s = (addr_s > 3'd4);
    assign wr_ok_s    = PSEL & PENABLE & PWRITE & ~bad_addr_s;

    // Distance to target in 25 bits so the compare can never wrap.
    assign up_s   = ({1'b0, target_r} > {1'b0, width_r});
    assign diff_s = up_s ? ({1'b0, target_r} - {1'b0, width_r})
                         : ({1'b0, width_r} - {1'b0, target_r});
    assign near_s = (step_r == 16'd0) || (diff_s <= {9'd0, step_r});

    // Free-running frame counter producing one tick per frame.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            count_r <= '0;
        end else if (tick_s) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // Slew state machine next-state and width update.
    always_comb begin
        state_n_s  = state_r;
        width_n_s  = width_r;
        strobe_n_s = 1'b0;
        done_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_r && (width_r != target_r)) begin
                    state_n_s = ST_MOVING;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_MOVING: begin
                if (!enable_r) begin
                    state_n_s = ST_IDLE;
                end else if (tick_s) begin
                    strobe_n_s = 1'b1;
                    if (near_s) begin
                        width_n_s  = target_r;
                        done_set_s = 1'b1;
                        state_n_s  = ST_IDLE;
                    end else if (up_s) begin
                        width_n_s = width_r + {8'd0, step_r};
                    end else begin
                        width_n_s = width_r - {8'd0, step_r};
                    end
                end else begin
                    state_n_s = ST_MOVING;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Slew state, commanded width and change strobe.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r  <= ST_IDLE;
            width_r  <= RESET_W;
            strobe_r <= 1'b0;
        end else begin
            state_r  <= state_n_s;
            width_r  <= width_n_s;
            strobe_r <= strobe_n_s;
        end
    end

    // Firmware-visible configuration registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            target_r <= RESET_W;
            step_r   <= 16'd1;
            enable_r <= 1'b0;
            irq_en_r <= 1'b0;
        end else if (wr_ok_s) begin
            case (addr_s)
                A_TARGET: target_r <= clamp_width(PWDATA[23:0]);
                A_STEP:   step_r   <= PWDATA[15:0];
                A_CTRL: begin
                    enable_r <= PWDATA[0];
                    irq_en_r <= PWDATA[1];
                end
                default: begin
                    target_r <= target_r;
                end
            endcase
        end else begin
            target_r <= target_r;
        end
    end

    // Sticky completion flag; a set on the same cycle as a W1C wins.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            done_r <= 1'b0;
        end else if (done_set_s) begin
            done_r <= 1'b1;
        end else if (wr_ok_s && (addr_s == A_STATUS) && PWDATA[1]) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_r;
        end
    end

    // Combinational read mux, driven only while selected.
    always_comb begin
        rdata_s = 32'd0;
        if (PSEL) begin
            case (addr_s)
                A_TARGET:  rdata_s = {8'd0, target_r};
                A_STEP:    rdata_s = {16'd0, step_r};
                A_CTRL:    rdata_s = {30'd0, irq_en_r, enable_r};
                A_STATUS:  rdata_s = {30'd0, done_r, (state_r == ST_MOVING)};
                A_CURRENT: rdata_s = {8'd0, width_r};
                default:   rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign PRDATA       = rdata_s;
    assign PREADY       = 1'b1;
    assign PSLVERR      = PSEL & PENABLE & bad_addr_s;
    assign width        = width_r;
    assign width_strobe = strobe_r;
    assign FABINT       = done_r & irq_en_r;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Directed self-checking bench for servo_slew_ctrl with a 100-cycle frame.
module tb_servo_slew_ctrl;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [23:0] width;
    logic        width_strobe;
    logic        FABINT;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int strobe_cyc = 0;

    servo_slew_ctrl #(.FRAME_CYCLES(100)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .width(width),
        .width_strobe(width_strobe), .FABINT(FABINT)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;
    always @(negedge PCLK) if (width_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 d = PRDATA; err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        apb_read(a, d, e);
        chk(tag, d, exp);
    endtask

    task automatic wait_strobe(input string tag, input logic [31:0] exp_w);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 250; i++) begin
            @(negedge PCLK);
            if (width_strobe === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, {31'd0, got}, 32'd1);
        if (got) chk(tag, {8'd0, width}, exp_w);
        strobe_cyc = cyc;
    endtask

    initial begin
        logic [31:0] d;
        logic e;
        int base;
        int c1;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd0; PWDATA = 32'd0;
        repeat (3) @(posedge PCLK);
        #2 PRESET = 1'b0;

        // Reset asserted mid-frame, checked without any clock edge.
        repeat (37) @(posedge PCLK);
        #3 PRESET = 1'b1;
        #1;
        chk("rst_width", {8'd0, width}, 32'd90000);
        chk("rst_fabint", {31'd0, FABINT}, 32'd0);
        chk("rst_strobe", {31'd0, width_strobe}, 32'd0);
        PSEL = 1'b1; PADDR = 32'h10;
        #1 chk("rst_current_nclk", PRDATA, 32'd90000);
        PADDR = 32'h0C;
        #1 chk("rst_status_nclk", PRDATA, 32'd0);
        PSEL = 1'b0;
        #1 chk("rdata_unsel", PRDATA, 32'd0);
        @(posedge PCLK); #2 PRESET = 1'b0;
        rd_chk("rst_target", 32'h00, 32'd90000);
        rd_chk("rst_step", 32'h04, 32'd1);
        rd_chk("rst_ctrl", 32'h08, 32'd0);
        chk("pready", {31'd0, PREADY}, 32'd1);

        // Ramp up in three 20000 steps.
        base = strobe_cnt;
        wr(32'h04, 32'd20000);
        wr(32'h00, 32'd150000);
        wr(32'h08, 32'd1);
        wait_strobe("ramp1", 32'd110000);
        c1 = strobe_cyc;
        wait_strobe("ramp2", 32'd130000);
        chk("tick_period", strobe_cyc - c1, 32'd100);
        wait_strobe("ramp3", 32'd150000);
        rd_chk("ramp_status", 32'h0C, 32'd2);
        repeat (150) @(posedge PCLK);
        chk("ramp_strobes", strobe_cnt - base, 32'd3);
        chk("ramp_fabint_off", {31'd0, FABINT}, 32'd0);

        // Clamp high, reach 250000, interrupt then W1C.
        wr(32'h0C, 32'd2);
        rd_chk("w1c_status", 32'h0C, 32'd0);
        wr(32'h08, 32'd3);
        wr(32'h00, 32'h00FFFFFF);
        rd_chk("clamp_hi", 32'h00, 32'd250000);
        wait_strobe("cl1", 32'd170000);
        wait_strobe("cl2", 32'd190000);
        wait_strobe("cl3", 32'd210000);
        wait_strobe("cl4", 32'd230000);
        chk("fabint_pre", {31'd0, FABINT}, 32'd0);
        wait_strobe("cl5", 32'd250000);
        #1 chk("fabint_set", {31'd0, FABINT}, 32'd1);
        wr(32'h0C, 32'd2);
        chk("fabint_clr", {31'd0, FABINT}, 32'd0);

        // STEP=0 jumps straight to the target in one update.
        base = strobe_cnt;
        wr(32'h04, 32'd0);
        wr(32'h00, 32'd70000);
        wait_strobe("jump", 32'd70000);
        repeat (150) @(posedge PCLK);
        chk("jump_strobes", strobe_cnt - base, 32'd1);
        rd_chk("jump_status", 32'h0C, 32'd2);
        wr(32'h0C, 32'd2);

        // Reversal mid-ramp.
        wr(32'h04, 32'd40000);
        wr(32'h00, 32'd250000);
        wait_strobe("rev_a", 32'd110000);
        wait_strobe("rev_b", 32'd150000);
        wr(32'h00, 32'd100000);
        wait_strobe("rev_c", 32'd110000);
        rd_chk("rev_busy", 32'h0C, 32'd1);
        wait_strobe("rev_d", 32'd100000);
        rd_chk("rev_done", 32'h0C, 32'd2);
        wr(32'h0C, 32'd2);

        // Disable mid-move freezes width; re-enable resumes.
        wr(32'h00, 32'd200000);
        wait_strobe("dis_a", 32'd140000);
        wr(32'h08, 32'd2);
        rd_chk("dis_status", 32'h0C, 32'd0);
        base = strobe_cnt;
        repeat (150) @(posedge PCLK);
        chk("dis_frozen", {8'd0, width}, 32'd140000);
        chk("dis_strobes", strobe_cnt - base, 32'd0);
        wr(32'h08, 32'd3);
        wait_strobe("dis_b", 32'd180000);
        wait_strobe("dis_c", 32'd200000);
        rd_chk("dis_done", 32'h0C, 32'd2);

        // Unmapped address 0x14 and low clamp.
        apb_write(32'h14, 32'h00000000, e);
        chk("slverr_wr", {31'd0, e}, 32'd1);
        apb_read(32'h14, d, e);
        chk("slverr_rd", {31'd0, e}, 32'd1);
        apb_read(32'h00, d, e);
        chk("slverr_ok", {31'd0, e}, 32'd0);
        chk("err_target", d, 32'd200000);
        rd_chk("err_step", 32'h04, 32'd40000);
        rd_chk("err_ctrl", 32'h08, 32'd3);
        wr(32'h08, 32'd0);
        wr(32'h00, 32'd1000);
        rd_chk("clamp_lo", 32'h00, 32'd50000);

        // Reset during a move.
        wr(32'h04, 32'd1000);
        wr(32'h08, 32'd3);
        wait_strobe("mv_rst", 32'd199000);
        repeat (20) @(posedge PCLK);
        #4 PRESET = 1'b1;
        #1;
        chk("mrst_width", {8'd0, width}, 32'd90000);
        chk("mrst_fabint", {31'd0, FABINT}, 32'd0);
        PSEL = 1'b1; PADDR = 32'h00;
        #1 chk("mrst_target", PRDATA, 32'd90000);
        PADDR = 32'h08;
        #1 chk("mrst_ctrl", PRDATA, 32'd0);
        PSEL = 1'b0;
        @(posedge PCLK); #2 PRESET = 1'b0;
        repeat (5) @(posedge PCLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servo_slew_ctrl.md
Name: servo_slew_ctrl

Overview:
APB3 slave that sits directly upstream of the servo PWM generator and drives its pulse-width input. Firmware writes a target pulse width and a step size. The block then moves the commanded width toward the target by at most one step per servo frame, so the horn slews smoothly instead of jumping. It raises a completion interrupt when the target is reached.

Parameters:
FRAME_CYCLES, 2000000, PCLK cycles per servo frame; one slew update per frame.
MIN_WIDTH, 50000, lowest legal pulse width in PCLK cycles; targets below are clamped up to this value.
MAX_WIDTH, 250000, highest legal pulse width in PCLK cycles; targets above are clamped down to this value.
RESET_WIDTH, 90000, width driven out of reset (0-degree position).

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
PSEL  in  1  APB peripheral select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write/read select
PADDR  in  32  APB address; only [4:2] decoded
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  constant 1
PSLVERR  out  1  error on unmapped access
width  out  24  commanded pulse width to the PWM stage
width_strobe  out  1  one-cycle pulse when width changes
FABINT  out  1  level interrupt = done & irq_en

Behaviour:
- Reset (async assert, sync release):
  - width=RESET_WIDTH, target=RESET_WIDTH, step=1, enable=0, irq_en=0, done=0, state=IDLE.
  - Frame counter=0, width_strobe=0, FABINT=0.
- APB:
  - Write occurs when PSEL & PENABLE & PWRITE.
  - PRDATA is combinational from PADDR[4:2] whenever PSEL=1, and 0 otherwise.
  - Unused bits read 0.
  - PSLVERR=1 only during an access phase (PSEL & PENABLE) to an address with PADDR[4:2] > 4. Such writes have no effect.
- Register map:
  - 0x00 TARGET [23:0] R/W. A written value is clamped to [MIN_WIDTH, MAX_WIDTH] before storage; readback shows the clamped value.
  - 0x04 STEP [15:0] R/W. 0 means jump to target in one update.
  - 0x08 CTRL R/W: bit0 enable, bit1 irq_en.
  - 0x0C STATUS: bit0 busy (R), bit1 done (R/W1C).
  - 0x10 CURRENT [23:0] R: width.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1, then wraps to 0.
  - tick = (count == FRAME_CYCLES-1).
  - Free-running regardless of enable.
- State machine:
  - IDLE -> MOVING on a cycle where enable=1 and width != target.
  - MOVING, on tick:
    - diff = |target - width| (25-bit compare, no wrap).
    - If step == 0 or diff <= step: width <= target, pulse width_strobe, set done, go to IDLE.
    - Otherwise width <= width ± step toward target and pulse width_strobe.
  - MOVING -> IDLE immediately when enable is cleared. width holds its value and done is not set.
  - busy = (state == MOVING).
- Simultaneous events:
  - TARGET write on a tick cycle: the update uses the old target; the new target takes effect from the next tick.
  - TARGET write equal to the current width while IDLE: no move, done not set.
  - TARGET write while MOVING: redirects the move, and the direction may reverse.
  - done set and W1C on the same cycle: set wins.
  - STEP write mid-move: used from the next tick.
- Latency:
  - width changes exactly on the cycle after tick.
  - width_strobe is high on the same cycle width changes.
  - First update occurs at the first tick after entering MOVING, which is up to FRAME_CYCLES later.
- Reset mid-move: all state returns to reset values immediately; width = RESET_WIDTH.

Test Plan:
Run all scenarios with FRAME_CYCLES=100.
- Reset: assert PRESET mid-frame -> width=90000, FABINT=0, STATUS=0, CURRENT reads 90000 without waiting for PCLK.
- Ramp up: STEP=20000, TARGET=150000, CTRL=1 -> width goes 110000, 130000, 150000 on three consecutive ticks. done=1 after the third tick, busy=0, exactly three width_strobe pulses.
- Clamp and interrupt: CTRL=3, TARGET write 0x00FFFFFF -> TARGET reads 250000, width reaches 250000. FABINT rises, then falls after a W1C write of 0x2 to STATUS.
- Reversal: while ramping up at 150000 toward 250000 with STEP=40000, write TARGET=100000 -> next tick width=110000, following tick width=100000, done=1.
- Disable mid-move: clear CTRL.enable between ticks -> width frozen, busy=0, done=0. Re-enabling resumes from the frozen value.
- Error and edge cases:
  - Read or write at 0x14 -> PSLVERR=1 in the access phase, no register changes.
  - STEP=0 -> width jumps to target on a single tick.
